// File: rtl/flop_pipe_pkg.sv
// -----------------------------------------------------------------------------
// flop_pipe_pkg
//
// Purpose:
//   Shared constants and helper functions for the flop_pipe register pipeline.
//   The pipeline depth is bounded by a legal range. The width of the occupancy
//   counter is derived from the depth.
//
// Contents:
//   MIN_DEPTH, MAX_DEPTH - legal bounds for the DEPTH parameter
//   depth_legal()        - elaboration-time range check for DEPTH
//   count_bits()         - width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package flop_pipe_pkg;

  localparam int MIN_DEPTH = 1;
  localparam int MAX_DEPTH = 16;

  function automatic bit depth_legal(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

  // One extra code point is needed so that "all stages full" is representable.
  function automatic int count_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_pipe_stage.sv
// -----------------------------------------------------------------------------
// flop_pipe_stage
//
// Purpose:
//   Holds one slot of the flop_pipe pipeline. The slot is a valid flop plus
//   an enabled WIDTH-bit data register. Reset is asynchronous and clears both
//   the valid flop and the data register.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   flush      in   drops the slot's valid bit at the next edge
//   advance    in   slot may take a new value from its source this cycle
//   src_valid  in   valid bit offered by the source (previous slot or input)
//   src_data   in   payload offered by the source
//   valid      out  slot holds a live entry
//   data       out  slot payload
// -----------------------------------------------------------------------------
module flop_pipe_stage
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             advance,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush takes priority over advance. This drops the entry even if a new one
  // would otherwise shift in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= src_valid;
    end
  end

  // A bubble never overwrites the data register. A slot that advances onto an
  // empty source keeps its old payload; only the valid bit marks it dead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (advance && src_valid) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/flop_pipe.sv
// -----------------------------------------------------------------------------
// flop_pipe
//
// Purpose:
//   A DEPTH-stage valid/ready register pipeline with bubble collapsing. An
//   empty stage always accepts from upstream. The stall therefore only
//   propagates back through a contiguous run of full stages. Throughput is
//   one transfer per cycle while the downstream side is ready, and this holds
//   for DEPTH=1 as well.
//
// Ports:
//   clk        in   single rising-edge clock
//   reset      in   asynchronous active-high reset; empties the pipe at once
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage 0 can accept this cycle (never during flush/reset)
//   in_data    in   upstream payload
//   out_valid  out  last stage holds valid data
//   out_ready  in   downstream accepts this cycle
//   out_data   out  last-stage payload
//   flush      in   discard all in-flight entries at the next edge
//   count      out  number of valid stages
// -----------------------------------------------------------------------------
module flop_pipe
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = count_bits(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("flop_pipe: DEPTH=%0d outside legal range %0d..%0d",
           DEPTH, MIN_DEPTH, MAX_DEPTH);
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             accept;

  // A stage can advance when the stage downstream of it advances, or when the
  // stage itself is empty. The loop walks from the output toward the input
  // and carries the "can advance" term along as a running OR.
  always_comb begin : advance_chain
    logic run;
    adv = '0;
    run = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      run    = run | ~v[i];
      adv[i] = run;
    end
  end

  // in_ready is gated by reset so that nothing looks acceptable while the pipe
  // is being held empty.
  assign in_ready = adv[0] & ~flush & ~reset;
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = accept;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = v[i-1];
      assign src_data  = d[i-1];
    end

    flop_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .advance  (adv[i]),
      .src_valid(src_valid),
      .src_data (src_data),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  // Occupancy is the population count of the valid bits. It follows the valid
  // flops directly, so it drops to zero together with them on reset.
  always_comb begin : occupancy
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(v[i]);
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_flop_pipe.sv
// -----------------------------------------------------------------------------
// tb_flop_pipe
//
// Purpose:
//   Directed bench for flop_pipe. Four instances run side by side, with
//   DEPTH = 1, 2, 3 and 4. Inputs change 1ns after each rising edge. Outputs
//   are sampled on the falling edge, so a sample shows exactly what the next
//   rising edge will act on. Accepted payloads go into a per-instance
//   expected queue. A monitor pops that queue whenever an instance completes
//   an output handshake.
// -----------------------------------------------------------------------------
module tb_flop_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  logic       in_valid_d1, in_ready_d1, out_valid_d1, out_ready_d1, flush_d1;
  logic [7:0] in_data_d1, out_data_d1;
  logic [0:0] count_d1;

  logic       in_valid_d2, in_ready_d2, out_valid_d2, out_ready_d2, flush_d2;
  logic [7:0] in_data_d2, out_data_d2;
  logic [1:0] count_d2;

  logic       in_valid_d3, in_ready_d3, out_valid_d3, out_ready_d3, flush_d3;
  logic [7:0] in_data_d3, out_data_d3;
  logic [1:0] count_d3;

  logic       in_valid_d4, in_ready_d4, out_valid_d4, out_ready_d4, flush_d4;
  logic [7:0] in_data_d4, out_data_d4;
  logic [2:0] count_d4;

  flop_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_d1), .in_ready(in_ready_d1),
    .in_data(in_data_d1), .out_valid(out_valid_d1), .out_ready(out_ready_d1),
    .out_data(out_data_d1), .flush(flush_d1), .count(count_d1)
  );

  flop_pipe #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid_d2), .in_ready(in_ready_d2),
    .in_data(in_data_d2), .out_valid(out_valid_d2), .out_ready(out_ready_d2),
    .out_data(out_data_d2), .flush(flush_d2), .count(count_d2)
  );

  flop_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid_d3), .in_ready(in_ready_d3),
    .in_data(in_data_d3), .out_valid(out_valid_d3), .out_ready(out_ready_d3),
    .out_data(out_data_d3), .flush(flush_d3), .count(count_d3)
  );

  flop_pipe #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid_d4), .in_ready(in_ready_d4),
    .in_data(in_data_d4), .out_valid(out_valid_d4), .out_ready(out_ready_d4),
    .out_data(out_data_d4), .flush(flush_d4), .count(count_d4)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] q_d1[$];
  logic [7:0] q_d2[$];
  logic [7:0] q_d3[$];
  logic [7:0] q_d4[$];

  logic [7:0] vec_a [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] vec_b [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
  int         exp_count_a [5] = '{0, 1, 2, 2, 1};

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic valid, input logic [7:0] data,
                               input logic ready, input logic fl);
    case (idx)
      1: begin in_valid_d1 = valid; in_data_d1 = data; out_ready_d1 = ready; flush_d1 = fl; end
      2: begin in_valid_d2 = valid; in_data_d2 = data; out_ready_d2 = ready; flush_d2 = fl; end
      3: begin in_valid_d3 = valid; in_data_d3 = data; out_ready_d3 = ready; flush_d3 = fl; end
      default: begin in_valid_d4 = valid; in_data_d4 = data; out_ready_d4 = ready; flush_d4 = fl; end
    endcase
  endtask

  task automatic pushExpected(input int idx, input logic [7:0] val);
    case (idx)
      1: q_d1.push_back(val);
      2: q_d2.push_back(val);
      3: q_d3.push_back(val);
      default: q_d4.push_back(val);
    endcase
  endtask

  task automatic clearExpected(input int idx);
    case (idx)
      1: q_d1.delete();
      2: q_d2.delete();
      3: q_d3.delete();
      default: q_d4.delete();
    endcase
  endtask

  function automatic int qSize(input int idx);
    case (idx)
      1: return q_d1.size();
      2: return q_d2.size();
      3: return q_d3.size();
      default: return q_d4.size();
    endcase
  endfunction

  function automatic logic [7:0] popExpected(input int idx);
    case (idx)
      1: return q_d1.pop_front();
      2: return q_d2.pop_front();
      3: return q_d3.pop_front();
      default: return q_d4.pop_front();
    endcase
  endfunction

  // Pops and compares one transfer. An output with nothing expected is a
  // duplicated or invented entry.
  task automatic scoreOutput(input int idx, input logic [7:0] got);
    logic [7:0] want;
    if (qSize(idx) == 0) begin
      n_checks++;
      $display("[TB] FAIL sb_unexpected_d%0d: got 0x%0h, expected no transfer at %0t", idx, got, $time);
    end else begin
      want = popExpected(idx);
      checkOutput($sformatf("sb_order_d%0d", idx), 32'(got), 32'(want));
    end
  endtask

  // Monitor: every completed output handshake is scored against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid_d1 && out_ready_d1) scoreOutput(1, out_data_d1);
      if (out_valid_d2 && out_ready_d2) scoreOutput(2, out_data_d2);
      if (out_valid_d3 && out_ready_d3) scoreOutput(3, out_data_d3);
      if (out_valid_d4 && out_ready_d4) scoreOutput(4, out_data_d4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keeps the run bounded even if something above stalls.
  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    for (int i = 1; i <= 4; i++) applyStimulus(i, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid_d2), 0);
    checkOutput("rst_count", 32'(count_d2), 0);
    checkOutput("rst_in_ready", 32'(in_ready_d2), 0);
    checkOutput("rst_out_data", 32'(out_data_d2), 0);
    tick();
    tick();
    reset = 1'b0;

    // Stream through DEPTH=2 with out_ready held high
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 3) begin
        applyStimulus(2, 1'b1, vec_a[k], 1'b1, 1'b0);
        pushExpected(2, vec_a[k]);
      end else begin
        applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      @(negedge clk);
      if (k < 3) checkOutput("a_in_ready", 32'(in_ready_d2), 1);
      checkOutput("a_count", 32'(count_d2), exp_count_a[k]);
      if (k < 2) begin
        checkOutput("a_out_valid_lat", 32'(out_valid_d2), 0);
      end else begin
        checkOutput("a_out_valid", 32'(out_valid_d2), 1);
        checkOutput("a_out_data", 32'(out_data_d2), 32'(vec_a[k-2]));
      end
    end
    tick();
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("a_count_end", 32'(count_d2), 0);

    // Backpressure on DEPTH=3
    for (int k = 0; k < 4; k++) begin
      tick();
      applyStimulus(3, 1'b1, vec_b[k], 1'b0, 1'b0);
      pushExpected(3, vec_b[k]);
      @(negedge clk);
      checkOutput("b_in_ready", 32'(in_ready_d3), 32'(k < 3));
      checkOutput("b_count", 32'(count_d3), k);
    end
    tick();
    @(negedge clk);
    checkOutput("b_full_in_ready", 32'(in_ready_d3), 0);
    checkOutput("b_full_count", 32'(count_d3), 3);
    checkOutput("b_hold_data", 32'(out_data_d3), 32'h41);
    tick();
    applyStimulus(3, 1'b1, 8'h44, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("b_pass_in_ready", 32'(in_ready_d3), 1);
    checkOutput("b_pass_out_data", 32'(out_data_d3), 32'h41);
    tick();
    applyStimulus(3, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b_after_count", 32'(count_d3), 3);
    checkOutput("b_after_data", 32'(out_data_d3), 32'h42);
    checkOutput("b_after_in_ready", 32'(in_ready_d3), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      applyStimulus(3, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    tick();
    applyStimulus(3, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b_drain_count", 32'(count_d3), 0);

    // Bubble collapse on DEPTH=4
    tick();
    applyStimulus(4, 1'b1, 8'hA5, 1'b0, 1'b0);
    pushExpected(4, 8'hA5);
    @(negedge clk);
    checkOutput("c_in_ready0", 32'(in_ready_d4), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      applyStimulus(4, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("c_count", 32'(count_d4), 1);
      checkOutput("c_in_ready", 32'(in_ready_d4), 1);
      checkOutput("c_out_valid", 32'(out_valid_d4), 32'(k == 4));
    end
    checkOutput("c_out_data", 32'(out_data_d4), 32'hA5);
    tick();
    applyStimulus(4, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(4, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("c_drain_count", 32'(count_d4), 0);

    // Flush on DEPTH=2: the output transfer in the flush cycle still completes
    tick();
    applyStimulus(2, 1'b1, 8'h5A, 1'b0, 1'b0);
    pushExpected(2, 8'h5A);
    tick();
    applyStimulus(2, 1'b1, 8'h6B, 1'b0, 1'b0);
    pushExpected(2, 8'h6B);
    tick();
    applyStimulus(2, 1'b1, 8'h77, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("d_flush_in_ready", 32'(in_ready_d2), 0);
    checkOutput("d_flush_count_before", 32'(count_d2), 2);
    checkOutput("d_flush_out_data", 32'(out_data_d2), 32'h5A);
    tick();
    checkOutput("d_flush_sb_left", qSize(2), 1);
    clearExpected(2);
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("d_flush_count", 32'(count_d2), 0);
    checkOutput("d_flush_out_valid", 32'(out_valid_d2), 0);

    // Async reset between edges on DEPTH=2 with two entries held
    tick();
    applyStimulus(2, 1'b1, 8'h81, 1'b0, 1'b0);
    pushExpected(2, 8'h81);
    tick();
    applyStimulus(2, 1'b1, 8'h82, 1'b0, 1'b0);
    pushExpected(2, 8'h82);
    tick();
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("e_count_before", 32'(count_d2), 2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("e_rst_out_valid", 32'(out_valid_d2), 0);
    checkOutput("e_rst_count", 32'(count_d2), 0);
    checkOutput("e_rst_in_ready", 32'(in_ready_d2), 0);
    checkOutput("e_rst_out_data", 32'(out_data_d2), 0);
    clearExpected(2);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(2, 1'b1, 8'h99, 1'b1, 1'b0);
    pushExpected(2, 8'h99);
    @(negedge clk);
    checkOutput("e_post_in_ready", 32'(in_ready_d2), 1);
    tick();
    applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("e_post_count", 32'(count_d2), 1);
    checkOutput("e_post_out_valid", 32'(out_valid_d2), 0);
    tick();
    @(negedge clk);
    checkOutput("e_post_out_data", 32'(out_data_d2), 32'h99);
    tick();
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("e_end_count", 32'(count_d2), 0);

    // DEPTH=1 with out_ready toggling under continuous in_valid
    for (int k = 0; k < 10; k++) begin
      tick();
      applyStimulus(1, 1'b1, 8'(8'hC0 + (k + 1) / 2), 1'(k % 2 == 0), 1'b0);
      if (k % 2 == 0) pushExpected(1, 8'(8'hC0 + k / 2));
      @(negedge clk);
      checkOutput("f_toggle_in_ready", 32'(in_ready_d1), 32'(k % 2 == 0));
    end
    // DEPTH=1 full-rate streaming
    for (int k = 0; k < 4; k++) begin
      tick();
      applyStimulus(1, 1'b1, 8'(8'hD0 + k), 1'b1, 1'b0);
      pushExpected(1, 8'(8'hD0 + k));
      @(negedge clk);
      checkOutput("f_rate_in_ready", 32'(in_ready_d1), 1);
    end
    tick();
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("f_end_count", 32'(count_d1), 0);

    // Every issued payload must have come out
    tick();
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("sb_empty_d%0d", i), qSize(i), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
